// File: rtl/udm_pkg.sv
// Shared UART definitions: FSM state encodings and 8N1 frame constants.
// Used by the RX path here and reusable by the TX path.
package udm_pkg;

    // Receiver FSM states. The three-bit encoding leaves codes 5..7 unused;
    // the FSM maps them back to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // 8N1 framing: eight data bits, LSB first, no parity, one stop bit at level 1.
    localparam int         DATA_BITS    = 8;
    localparam logic       STOP_LEVEL   = 1'b1;
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/udm_uart_rx_if.sv
// Receive-side output bundle of the UART: the byte strobe, the byte itself,
// the framing-error strobe and the busy flag. The receiver drives it through
// the master modport, and the debug controller reads it through the slave modport.
interface udm_uart_rx_if;

    logic       rx_done_tick_o;
    logic [7:0] rx_dout_bo;
    logic       frame_err_o;
    logic       busy_o;

    modport master (
        output rx_done_tick_o,
        output rx_dout_bo,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        input rx_done_tick_o,
        input rx_dout_bo,
        input frame_err_o,
        input busy_o
    );

endinterface

// File: rtl/udm_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to 1, which is the idle level of a UART line. At reset
// release the line therefore looks idle until real data has crossed both stages.
module udm_sync2 (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // Two back-to-back registers. The first one can go metastable, and the second one gives it a cycle to settle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            meta <= 1'b1;
            q_o  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep the two stages distinct;
            // with blocking ones both flops would collapse into a single register.
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/udm_uart_rx.sv
// UART 8N1 receiver. It finds the falling edge of the start bit, checks the
// start bit again at its midpoint, and then samples each data bit and the stop
// bit one bit period apart. Each byte with a valid stop bit is presented with
// a one-cycle done tick. A low stop bit gives a one-cycle frame error instead.
// The FSM then waits in ST_BREAK until the line returns high.
module udm_uart_rx
    import udm_pkg::*;
#(
    parameter int BAUD_DIVIDER = 868
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           rx_i,
    udm_uart_rx_if.master  rx_if
);

    localparam int CNT_W = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIVIDER / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIVIDER - 1);

    logic              rxs;
    uart_state_e       state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic [7:0]        dout;
    logic              done_tick;
    logic              frame_err;

    logic              at_half, at_full;
    logic              cnt_clr, idx_clr, idx_inc, shift_en, dout_load, err_set;

    udm_sync2 u_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (rx_i),
        .q_o       (rxs)
    );

    assign at_half = (cnt == HALF_LAST);
    assign at_full = (cnt == FULL_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Next-state logic. The start bit is checked at half a bit period and
    // every later bit at a full bit period.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!rxs)    state_next = ST_START;
            ST_START: if (at_half) state_next = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (at_full && (bit_idx == LAST_BIT_IDX)) state_next = ST_STOP;
            ST_STOP:  if (at_full) state_next = (rxs == STOP_LEVEL) ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs)     state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Datapath control for the current state. The counter clears on every
    // state change and at each data-bit sample point.
    always_comb begin
        // NOTE: every output gets a default before the case. A path that
        // leaves one unassigned would otherwise infer a latch.
        cnt_clr   = (state_next != state);
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        shift_en  = 1'b0;
        dout_load = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_START: begin
                if (at_half && !rxs) idx_clr = 1'b1;
            end
            ST_DATA: begin
                if (at_full) begin
                    shift_en = 1'b1;
                    cnt_clr  = 1'b1;
                    if (bit_idx != LAST_BIT_IDX) idx_inc = 1'b1;
                end
            end
            ST_STOP: begin
                if (at_full) begin
                    if (rxs == STOP_LEVEL) dout_load = 1'b1;
                    else                   err_set   = 1'b1;
                end
            end
            default: begin
                // In IDLE and BREAK the counter is held at zero.
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Bit timer, bit index, shift register, output byte and the registered
    // strobes. The tick is registered on the same edge that loads the byte,
    // so the consumer sees the tick and the matching byte in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dout      <= '0;
            done_tick <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_clr ? '0 : cnt + 1'b1;
            if (idx_clr)      bit_idx <= '0;
            else if (idx_inc) bit_idx <= bit_idx + 1'b1;
            if (shift_en)     shreg   <= {rxs, shreg[7:1]};
            if (dout_load)    dout    <= shreg;
            done_tick <= dout_load;
            frame_err <= err_set;
        end
    end

    assign rx_if.rx_done_tick_o = done_tick;
    assign rx_if.rx_dout_bo     = dout;
    assign rx_if.frame_err_o    = frame_err;
    assign rx_if.busy_o         = (state != ST_IDLE);

endmodule

// File: tb/tb_udm_uart_rx.sv
// Bench for udm_uart_rx with BAUD_DIVIDER=16. Stimulus pushes the expected
// events (byte or frame error) into a queue. A monitor pops one entry on each
// done tick or frame-error pulse and compares it against the DUT output.
module tb_udm_uart_rx;

    localparam int DIV    = 16;
    localparam int HALF   = 50;           // half clock period, time units
    localparam int BIT_T  = DIV * 2 * HALF; // nominal bit period (1600)
    localparam int BIT_SL = 1648;         // 3% slow
    localparam int BIT_FS = 1552;         // 3% fast

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    logic rx_i      = 1'b1;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    exp_t exp_q[$];

    udm_uart_rx_if rx_if ();

    udm_uart_rx #(.BAUD_DIVIDER(DIV)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .rx_i      (rx_i),
        .rx_if     (rx_if)
    );

    always #(HALF) clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
        rx_i = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            #(bit_t);
        end
        rx_i = stop;
        #(bit_t);
        if (stop) rx_i = 1'b1;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = b;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    // Monitor: the outputs are sampled on the falling edge, half a cycle away from the update edge.
    initial begin : monitor
        logic [7:0] prev_dout;
        exp_t       e;
        prev_dout = 8'h00;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                prev_dout = rx_if.rx_dout_bo;
            end else begin
                if (rx_if.rx_done_tick_o && rx_if.frame_err_o)
                    check("tick_and_err_together", 1, 0);
                if (rx_if.rx_done_tick_o || rx_if.frame_err_o) begin
                    check("event_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("event_kind_is_err", rx_if.frame_err_o, e.is_err);
                        if (!e.is_err) check("rx_byte", rx_if.rx_dout_bo, e.data);
                        else           check("dout_kept_on_err", rx_if.rx_dout_bo, prev_dout);
                    end
                end
                if (!rx_if.rx_done_tick_o && (rx_if.rx_dout_bo !== prev_dout))
                    check("dout_hold", rx_if.rx_dout_bo, prev_dout);
                prev_dout = rx_if.rx_dout_bo;
            end
        end
    end

    initial begin : watchdog
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  t0;
        int  lat;
        bit  got;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_tick", rx_if.rx_done_tick_o, 0);
        check("rst_err",  rx_if.frame_err_o,    0);
        check("rst_dout", rx_if.rx_dout_bo,     8'h00);
        check("rst_busy", rx_if.busy_o,         0);
        reset_n_i = 1'b1;
        repeat (40) @(negedge clk_i);

        // 0x55 with latency window measured from the falling edge
        expect_byte(8'h55);
        @(negedge clk_i);
        t0  = cyc;
        got = 1'b0;
        lat = 0;
        fork
            send_frame(8'h55, 1'b1, BIT_T);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk_i);
                    if (rx_if.rx_done_tick_o) begin
                        got = 1'b1;
                        lat = cyc - t0;
                        break;
                    end
                end
            end
        join
        check("tick_seen_0x55", got, 1);
        check("latency_in_window", (lat >= 152 && lat <= 158), 1);
        #(2 * BIT_T);

        // Back-to-back frames without idle bits
        expect_byte(8'hA5);
        expect_byte(8'h00);
        expect_byte(8'hFF);
        @(negedge clk_i);
        send_frame(8'hA5, 1'b1, BIT_T);
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        #(2 * BIT_T);
        check("b2b_last_byte", rx_if.rx_dout_bo, 8'hFF);
        check("b2b_queue_empty", exp_q.size(), 0);

        // 4-cycle glitch on the idle line
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_i = 1'b1;
        check("glitch_busy_early", rx_if.busy_o, 1);
        repeat (8) @(negedge clk_i);
        check("glitch_idle_by_12", rx_if.busy_o, 0);
        #(2 * BIT_T);

        // Stop bit low, line held low for 40 bit periods
        expect_err();
        @(negedge clk_i);
        send_frame(8'h3C, 1'b0, BIT_T);
        #(BIT_T);
        check("break_busy", rx_if.busy_o, 1);
        #(38 * BIT_T);
        rx_i = 1'b1;
        #(2 * BIT_T);
        check("break_dout_unchanged", rx_if.rx_dout_bo, 8'hFF);
        check("break_exit_idle", rx_if.busy_o, 0);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1, BIT_T);
        #(2 * BIT_T);

        // Reset asserted during data bit 4
        @(negedge clk_i);
        rx_i = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'(8'hC3 >> i);
            #(BIT_T);
        end
        rx_i = 1'b0;
        #(BIT_T / 2);
        reset_n_i = 1'b0;
        rx_i      = 1'b1;
        repeat (2) @(negedge clk_i);
        check("midrst_tick", rx_if.rx_done_tick_o, 0);
        check("midrst_err",  rx_if.frame_err_o,    0);
        check("midrst_dout", rx_if.rx_dout_bo,     8'h00);
        check("midrst_busy", rx_if.busy_o,         0);
        reset_n_i = 1'b1;
        #(2 * BIT_T);
        expect_byte(8'h5A);
        @(negedge clk_i);
        send_frame(8'h5A, 1'b1, BIT_T);
        #(2 * BIT_T);

        // +/-3% baud mismatch
        expect_byte(8'h96);
        send_frame(8'h96, 1'b1, BIT_FS);
        #(2 * BIT_T);
        expect_byte(8'h96);
        send_frame(8'h96, 1'b1, BIT_SL);
        #(4 * BIT_T);

        check("all_events_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
